mux_scan_sequencer: RTL and testbench

Upstream driver and downstream collector for the 4-input, 1-bit selector multiplexer.
- Drives the mux's 2-bit selector through channels 0..3, holding each channel for DWELL cycles.
- Samples the mux output on the last cycle of each dwell.
- Presents the four captured bits as one 4-bit frame on a valid/ready handshake.
- Supports single-shot or continuous scanning.

---
 rtl/mux_scan_pkg.sv | 19 +
 rtl/mux_scan_sequencer_dwell_timer.sv | 34 +++
 rtl/mux_scan_sequencer.sv | 123 ++++++++++++
 tb/tb_mux_scan_sequencer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
// Shared constants and types for the 4-channel mux scan sequencer.
// Optional frame parity output is enabled by MUX_SCAN_PARITY_EN.
package mux_scan_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SCAN    = 2'd1;
    localparam logic [1:0] PRESENT = 2'd2;

    typedef logic [SEL_W-1:0]  sel_t;
    typedef logic [NUM_CH-1:0] frame_t;

    function automatic logic frame_par(input frame_t f);
        return ^f;
    endfunction

endpackage

// File: rtl/mux_scan_sequencer_dwell_timer.sv
// Dwell down-counter: reloads to DWELL-1, counts down while enabled,
// and stops at zero so it only ever wraps through a reload.
module dwell_timer #(
    parameter int CNT_W = 8,
    parameter int DWELL = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expired
);

    if (DWELL < 1 || longint'(DWELL) > (64'd1 << CNT_W)) begin : g_bad_dwell
        $error("dwell_timer: DWELL must lie in 1..2**CNT_W");
    end

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= RELOAD;
        end else if (en && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/mux_scan_sequencer.sv
// Scans a 4:1 mux selector, samples its output at the end of each dwell
// and hands the 4-bit frame out on valid/ready. Parity: MUX_SCAN_PARITY_EN.
module mux_scan_sequencer
    import mux_scan_pkg::*;
#(
    parameter int DWELL = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    output logic [SEL_W-1:0] selector,
    input  logic             salida,
    output logic [NUM_CH-1:0] frame,
    output logic             frame_valid,
    input  logic             frame_ready,
    output logic             busy
`ifdef MUX_SCAN_PARITY_EN
    ,
    output logic             frame_parity
`endif
);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [NUM_CH-2:0] shadow;
    logic              expired;
    logic              load;
    logic              en;
    logic              last_ch;
    frame_t            frame_nxt;

    assign last_ch   = (selector == SEL_W'(NUM_CH - 1));
    assign en        = (state == SCAN);
    assign frame_nxt = {salida, shadow};

    dwell_timer #(
        .CNT_W (CNT_W),
        .DWELL (DWELL)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .en      (en),
        .expired (expired)
    );

    // Reload the dwell on every scan entry and on each channel advance.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        unique case (1'b1)
            (state == IDLE): begin
                if (start) begin
                    state_nxt = SCAN;
                    load      = 1'b1;
                end
            end
            (state == SCAN): begin
                if (expired) begin
                    if (last_ch) begin
                        state_nxt = PRESENT;
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            (state == PRESENT): begin
                if (frame_ready) begin
                    if (mode) begin
                        state_nxt = SCAN;
                        load      = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            selector    <= '0;
            shadow      <= '0;
            frame       <= '0;
            frame_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != IDLE);
            if (state == SCAN && expired) begin
                if (last_ch) begin
                    frame       <= frame_nxt;
                    frame_valid <= 1'b1;
                    selector    <= '0;
                end else begin
                    shadow[selector] <= salida;
                    selector         <= selector + 1'b1;
                end
            end else if (state == PRESENT && frame_ready) begin
                frame_valid <= 1'b0;
            end else if (state == IDLE) begin
                selector <= '0;
            end
        end
    end

`ifdef MUX_SCAN_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_parity <= 1'b0;
        end else if (state == SCAN && expired && last_ch) begin
            frame_parity <= frame_par(frame_nxt);
        end
    end
`endif

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Randomized scoreboard bench: two sequencers (DWELL=1 and DWELL=4) each
// scan a modelled 4:1 mux that only settles on the last dwell cycle.
module tb_mux_scan_sequencer;

    localparam int DW0 = 1;
    localparam int DW1 = 4;

    function automatic int dw(input int i);
        return (i == 0) ? DW0 : DW1;
    endfunction

    typedef struct {
        logic [3:0] f;
        int         due;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_s [2];
    logic       mode_s  [2];
    logic       ready_s [2];
    logic       salida_s[2];
    logic [1:0] sel     [2];
    logic [3:0] frm     [2];
    logic       vld     [2];
    logic       busy_s  [2];
    logic [3:0] mux_in  [2];
    logic       noise   [2];
    int         stable  [2];
    logic [1:0] last_sel[2];
    logic       m_busy  [2];
    int         m_due   [2];
    ent_t       exp_q   [2][$];
    int         cyc = 0;
    int         n_chk = 0;
    int         n_fail = 0;
    logic       did_rst = 1'b0;
`ifdef MUX_SCAN_PARITY_EN
    logic       par     [2];
`endif

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Mux model: output is garbage until the selector has been stable
    // for DWELL-1 cycles.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            salida_s[i] = noise[i];
            if (stable[i] >= dw(i) - 1) salida_s[i] = mux_in[i][sel[i]];
        end
    end

    mux_scan_sequencer #(.DWELL(DW0), .CNT_W(8)) u_dut0 (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start_s[0]),
        .mode        (mode_s[0]),
        .selector    (sel[0]),
        .salida      (salida_s[0]),
        .frame       (frm[0]),
        .frame_valid (vld[0]),
        .frame_ready (ready_s[0]),
        .busy        (busy_s[0])
`ifdef MUX_SCAN_PARITY_EN
        ,
        .frame_parity(par[0])
`endif
    );

    mux_scan_sequencer #(.DWELL(DW1), .CNT_W(8)) u_dut1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start_s[1]),
        .mode        (mode_s[1]),
        .selector    (sel[1]),
        .salida      (salida_s[1]),
        .frame       (frm[1]),
        .frame_valid (vld[1]),
        .frame_ready (ready_s[1]),
        .busy        (busy_s[1])
`ifdef MUX_SCAN_PARITY_EN
        ,
        .frame_parity(par[1])
`endif
    );

    task automatic check(input string nm, input int i, input int act,
                         input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s inst%0d cyc=%0d actual=%0h required=%0h",
                     nm, i, cyc, act, req);
        end
    endtask

    task automatic check_zero(input string nm);
        for (int i = 0; i < 2; i++) begin
            check({nm, "_selector"}, i, int'(sel[i]), 0);
            check({nm, "_frame"}, i, int'(frm[i]), 0);
            check({nm, "_valid"}, i, int'(vld[i]), 0);
            check({nm, "_busy"}, i, int'(busy_s[i]), 0);
`ifdef MUX_SCAN_PARITY_EN
            check({nm, "_parity"}, i, int'(par[i]), 0);
`endif
        end
    endtask

    // Monitor: derives expected outputs from the scoreboard head.
    always @(negedge clk) begin
        int         due;
        int         s;
        logic       have;
        logic       ev;
        logic [1:0] esel;
        for (int i = 0; i < 2; i++) begin
            if (rst_n) begin
                have = (exp_q[i].size() != 0);
                ev   = 1'b0;
                esel = 2'd0;
                if (have) begin
                    due = exp_q[i][0].due;
                    s   = due - 4 * dw(i);
                    if (cyc >= due) ev = 1'b1;
                    else esel = 2'((cyc - s) / dw(i));
                end
                check("busy", i, int'(busy_s[i]), int'(have));
                check("frame_valid", i, int'(vld[i]), int'(ev));
                check("selector", i, int'(sel[i]), int'(esel));
                if (ev) begin
                    check("frame", i, int'(frm[i]), int'(exp_q[i][0].f));
`ifdef MUX_SCAN_PARITY_EN
                    check("frame_parity", i, int'(par[i]),
                          int'(^exp_q[i][0].f));
`endif
                    if (ready_s[i]) void'(exp_q[i].pop_front());
                end
            end
            if (sel[i] == last_sel[i]) stable[i] = stable[i] + 1;
            else stable[i] = 0;
            last_sel[i] = sel[i];
            noise[i]    = 1'($urandom);
        end
    end

    initial begin
        logic begin_scan;
        logic drain;
        int   ch;
        for (int i = 0; i < 2; i++) begin
            start_s[i]  = 1'b0;
            mode_s[i]   = 1'b0;
            ready_s[i]  = 1'b0;
            mux_in[i]   = 4'h0;
            noise[i]    = 1'b0;
            stable[i]   = 0;
            last_sel[i] = 2'd0;
            m_busy[i]   = 1'b0;
            m_due[i]    = 0;
        end
        #2;
        check_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int it = 0; it < 4000; it++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                begin_scan = 1'b0;
                if (!m_busy[i]) begin
                    if (start_s[i]) begin_scan = 1'b1;
                end else if (cyc - 1 >= m_due[i] && ready_s[i]) begin
                    if (mode_s[i]) begin_scan = 1'b1;
                    else m_busy[i] = 1'b0;
                end
                if (begin_scan) begin
                    m_busy[i] = 1'b1;
                    m_due[i]  = cyc + 4 * dw(i);
                    mux_in[i] = 4'($urandom);
                    exp_q[i].push_back('{f: mux_in[i], due: m_due[i]});
                end
            end

            ch = (cyc - (m_due[1] - 4 * DW1)) / DW1;
            if (!did_rst && it >= 1500 && m_busy[1] && cyc < m_due[1]
                && ch == 2) begin
                did_rst = 1'b1;
                #1 rst_n = 1'b0;
                #1 check_zero("abort");
                for (int i = 0; i < 2; i++) begin
                    exp_q[i].delete();
                    m_busy[i]  = 1'b0;
                    start_s[i] = 1'b0;
                    mode_s[i]  = 1'b0;
                    ready_s[i] = 1'b0;
                end
                @(negedge clk);
                #1 rst_n = 1'b1;
                continue;
            end

            drain = (it >= 3800);
            for (int i = 0; i < 2; i++) begin
                start_s[i] = !drain && ($urandom_range(0, 3) == 0);
                mode_s[i]  = !drain && ($urandom_range(0, 1) == 1);
                if (drain) ready_s[i] = 1'b1;
                else if ((it / 50) % 2 == 0)
                    ready_s[i] = ($urandom_range(0, 9) == 0);
                else
                    ready_s[i] = ($urandom_range(0, 2) != 0);
            end
        end

        for (int i = 0; i < 2; i++) begin
            check("drained", i, exp_q[i].size(), 0);
        end
        check("midscan_reset_hit", 1, int'(did_rst), 1);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
